// File: rtl/envelope_controller.sv
// ADSR envelope sequencer feeding the PDM encoder amplitude port.
// Optional macro ENVELOPE_RETRIGGER_EN: a gate rise in DECAY/SUSTAIN/RELEASE restarts ATTACK.
module envelope_controller #(
  parameter int DATA_BITS = 8,
  parameter int TICK_DIV  = 2080
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 gate,
  input  logic [DATA_BITS-1:0] attack_step,
  input  logic [DATA_BITS-1:0] decay_step,
  input  logic [DATA_BITS-1:0] sustain_level,
  input  logic [DATA_BITS-1:0] release_step,
  output logic [DATA_BITS-1:0] amplitude,
  output logic [2:0]           state,
  output logic                 busy
);

  // state   | meaning
  // IDLE    | amplitude held at 0, waiting for gate
  // ATTACK  | rising by attack_step per tick toward MAX
  // DECAY   | falling by decay_step per tick toward sustain_level
  // SUSTAIN | tracking sustain_level while gate is held
  // RELEASE | falling by release_step per tick toward 0
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DATA_BITS-1:0] MAX = {DATA_BITS{1'b1}};
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  state_t               cur_state, next_state;
  logic [DATA_BITS-1:0] amp_q, next_amp;
  logic [CW-1:0]        count;
  logic                 tick;

  function automatic logic [DATA_BITS-1:0] sat_add(input logic [DATA_BITS-1:0] a,
                                                   input logic [DATA_BITS-1:0] b);
    logic [DATA_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_BITS] ? MAX : s[DATA_BITS-1:0];
  endfunction

  function automatic logic [DATA_BITS-1:0] sat_sub(input logic [DATA_BITS-1:0] a,
                                                   input logic [DATA_BITS-1:0] b);
    logic [DATA_BITS:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DATA_BITS] ? '0 : d[DATA_BITS-1:0];
  endfunction

  assign tick = (count == TC);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

`ifdef ENVELOPE_RETRIGGER_EN
  logic gate_q;
  logic rise;

  always_ff @(posedge clock) begin
    if (reset) gate_q <= 1'b0;
    else       gate_q <= gate;
  end

  assign rise = gate & ~gate_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= S_IDLE;
      amp_q     <= '0;
    end else begin
      cur_state <= next_state;
      amp_q     <= next_amp;
    end
  end

  always_comb begin
    logic [DATA_BITS-1:0] dec_res;
    next_state = cur_state;
    next_amp   = amp_q;
    dec_res    = sat_sub(amp_q, decay_step);
    case (cur_state)
      S_IDLE: begin
        next_amp = '0;
        if (gate) next_state = S_ATTACK;
      end
      S_ATTACK: begin
        if (tick) begin
          next_amp = (attack_step == '0) ? MAX : sat_add(amp_q, attack_step);
          if (next_amp == MAX) next_state = S_DECAY;
        end
        if (!gate) next_state = S_RELEASE;
      end
      S_DECAY: begin
        if (tick) begin
          // A zero step, or arriving already at/below the target, lands on sustain directly.
          if (decay_step == '0 || amp_q <= sustain_level || dec_res < sustain_level)
            next_amp = sustain_level;
          else
            next_amp = dec_res;
          if (next_amp == sustain_level) next_state = S_SUSTAIN;
        end
        if (!gate) next_state = S_RELEASE;
`ifdef ENVELOPE_RETRIGGER_EN
        if (rise) next_state = S_ATTACK;
`endif
      end
      S_SUSTAIN: begin
        if (tick) next_amp = sustain_level;
        if (!gate) next_state = S_RELEASE;
`ifdef ENVELOPE_RETRIGGER_EN
        if (rise) next_state = S_ATTACK;
`endif
      end
      S_RELEASE: begin
        if (tick) begin
          next_amp = (release_step == '0) ? '0 : sat_sub(amp_q, release_step);
          if (next_amp == '0) next_state = S_IDLE;
        end
`ifdef ENVELOPE_RETRIGGER_EN
        // Retrigger keeps the current level; attack resumes from wherever release got to.
        if (rise) next_state = S_ATTACK;
`endif
      end
      default: begin
        next_state = S_IDLE;
        next_amp   = '0;
      end
    endcase
  end

  assign amplitude = amp_q;
  assign state     = cur_state;
  assign busy      = (cur_state != S_IDLE);

endmodule

// File: tb/tb_envelope_controller.sv
// Directed, table-driven bench for envelope_controller at TICK_DIV=4, DATA_BITS=8.
module tb_envelope_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       gate;
  logic [7:0] attack_step, decay_step, sustain_level, release_step;
  logic [7:0] amplitude;
  logic [2:0] state;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int phase  = 0;

  envelope_controller #(.DATA_BITS(8), .TICK_DIV(4)) dut (
    .clock(clock), .reset(reset), .gate(gate),
    .attack_step(attack_step), .decay_step(decay_step),
    .sustain_level(sustain_level), .release_step(release_step),
    .amplitude(amplitude), .state(state), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       g;
    logic [7:0] atk, dec, sus, rel;
    int         n_clk;   // 0 = advance to the next amplitude update
    logic [7:0] exp_amp;
    logic [2:0] exp_state;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] a, input logic [2:0] s,
                           input logic b);
    check({tag, " amplitude"}, int'(amplitude), int'(a));
    check({tag, " state"}, int'(state), int'(s));
    check({tag, " busy"}, int'(busy), int'(b));
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clock);
      phase = (phase + 1) % 4;
    end
    #1;
  endtask

  task automatic to_update();
    clocks((phase == 0) ? 4 : 4 - phase);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h40, 8'h20, 8'h80, 8'h00, 0, 8'h40, 3'd1, 1'b1};
    vecs[1]  = '{1'b1, 8'h40, 8'h20, 8'h80, 8'h00, 0, 8'h80, 3'd1, 1'b1};
    vecs[2]  = '{1'b1, 8'h40, 8'h20, 8'h80, 8'h00, 0, 8'hC0, 3'd1, 1'b1};
    vecs[3]  = '{1'b1, 8'h40, 8'h20, 8'h80, 8'h00, 0, 8'hFF, 3'd2, 1'b1};
    vecs[4]  = '{1'b1, 8'h40, 8'h20, 8'h80, 8'h00, 0, 8'hDF, 3'd2, 1'b1};
    vecs[5]  = '{1'b1, 8'h40, 8'h20, 8'h80, 8'h00, 0, 8'hBF, 3'd2, 1'b1};
    vecs[6]  = '{1'b1, 8'h40, 8'h20, 8'h80, 8'h00, 0, 8'h9F, 3'd2, 1'b1};
    vecs[7]  = '{1'b1, 8'h40, 8'h20, 8'h80, 8'h00, 0, 8'h80, 3'd3, 1'b1};
    vecs[8]  = '{1'b1, 8'h40, 8'h20, 8'h30, 8'h00, 0, 8'h30, 3'd3, 1'b1};
    vecs[9]  = '{1'b1, 8'h40, 8'h20, 8'h80, 8'h00, 0, 8'h80, 3'd3, 1'b1};
    vecs[10] = '{1'b0, 8'h40, 8'h20, 8'h80, 8'h50, 1, 8'h80, 3'd4, 1'b1};
    vecs[11] = '{1'b0, 8'h40, 8'h20, 8'h80, 8'h50, 0, 8'h30, 3'd4, 1'b1};
    vecs[12] = '{1'b0, 8'h40, 8'h20, 8'h80, 8'h50, 0, 8'h00, 3'd0, 1'b0};
    vecs[13] = '{1'b1, 8'h00, 8'h00, 8'h80, 8'h50, 0, 8'hFF, 3'd2, 1'b1};
    vecs[14] = '{1'b1, 8'h00, 8'h00, 8'h80, 8'h50, 0, 8'h80, 3'd3, 1'b1};

    reset = 1'b1; gate = 1'b0;
    attack_step = 8'h40; decay_step = 8'h20; sustain_level = 8'h80; release_step = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    phase = 0;
    check_all("reset", 8'h00, 3'd0, 1'b0);

    // Reset in the middle of an attack
    reset = 1'b0; gate = 1'b1;
    to_update();
    check_all("pre_reset", 8'h40, 3'd1, 1'b1);
    reset = 1'b1; gate = 1'b0;
    @(posedge clock); #1;
    phase = 0;
    check_all("mid_reset", 8'h00, 3'd0, 1'b0);
    reset = 1'b0;
    clocks(8);
    check_all("post_reset_idle", 8'h00, 3'd0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      gate = vecs[i].g;
      attack_step = vecs[i].atk; decay_step = vecs[i].dec;
      sustain_level = vecs[i].sus; release_step = vecs[i].rel;
      if (vecs[i].n_clk == 0) to_update();
      else clocks(vecs[i].n_clk);
      check_all($sformatf("vec%0d", i), vecs[i].exp_amp, vecs[i].exp_state, vecs[i].exp_busy);
    end

    // Release from 0x80 by 0x20, gate rises again at 0x60
    attack_step = 8'h10; release_step = 8'h20; gate = 1'b0;
    clocks(1);
    check_all("rel_enter", 8'h80, 3'd4, 1'b1);
    to_update();
    check_all("rel_60", 8'h60, 3'd4, 1'b1);
    gate = 1'b1;
    clocks(1);
`ifdef ENVELOPE_RETRIGGER_EN
    check_all("retrig_state", 8'h60, 3'd1, 1'b1);
    to_update();
    check_all("retrig_70", 8'h70, 3'd1, 1'b1);
    to_update();
    check_all("retrig_80", 8'h80, 3'd1, 1'b1);
`else
    check_all("no_retrig", 8'h60, 3'd4, 1'b1);
    to_update();
    check_all("rel_40", 8'h40, 3'd4, 1'b1);
    to_update();
    check_all("rel_20", 8'h20, 3'd4, 1'b1);
    to_update();
    check_all("rel_done", 8'h00, 3'd0, 1'b0);
    clocks(1);
    check_all("restart", 8'h00, 3'd1, 1'b1);
    to_update();
    check_all("restart_10", 8'h10, 3'd1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/envelope_controller.md
Name: envelope_controller

Overview:
ADSR envelope sequencer that drives the amplitude input of the PDM encoder.
- Driven by a gate (note on/off) and four envelope settings.
- Steps an amplitude level through Attack/Decay/Sustain/Release at a fixed tick rate derived from the system clock.
- Sits between note/control logic and the PDMEncoder amplitude port; replaces a free-running counter as the amplitude source.

Parameters:
- DATA_BITS, 8, width of amplitude, step and sustain values; must match the PDMEncoder DATA_BITS.
- TICK_DIV, 2080, clock cycles per envelope update tick (1 kHz at 2.08 MHz); legal range >= 2.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- gate  input  1  note held when high
- attack_step  input  DATA_BITS  level increment per tick in ATTACK
- decay_step  input  DATA_BITS  level decrement per tick in DECAY
- sustain_level  input  DATA_BITS  held level in SUSTAIN
- release_step  input  DATA_BITS  level decrement per tick in RELEASE
- amplitude  output  DATA_BITS  registered envelope level, to PDMEncoder amplitude
- state  output  3  current state encoding
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (sync, active-high) values: amplitude=0, state=IDLE, busy=0, tick counter=0, gate_q=0. Reset wins over every other event in the same cycle, including mid-envelope.
- State encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Values 5-7 are unreachable; if entered, go to IDLE with amplitude=0.
- Tick counter:
  - Free-running, counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where count==TICK_DIV-1.
  - Level arithmetic is applied only in tick cycles; state transitions caused by gate are applied in any cycle.
- gate is registered into gate_q; rise = gate & ~gate_q.
- MAX = 2^DATA_BITS-1. All sums and differences are computed at DATA_BITS+1 width, then saturated to [0, MAX]. No wrap-around.
- A step input of 0 means jump to the segment target on the next tick.
- IDLE: amplitude holds 0. If gate==1, go to ATTACK next cycle.
- ATTACK:
  - On tick, amplitude = min(amplitude+attack_step, MAX).
  - When the result equals MAX, go to DECAY in that same cycle.
- DECAY:
  - On tick, amplitude = max(amplitude-decay_step, sustain_level).
  - When the result equals sustain_level, go to SUSTAIN.
  - If entered with amplitude <= sustain_level, go to SUSTAIN on the first tick with amplitude=sustain_level.
- SUSTAIN: on tick, amplitude = sustain_level. sustain_level changes take effect at the next tick.
- Gate low in ATTACK, DECAY or SUSTAIN: go to RELEASE on the next clock. amplitude keeps its current value until the next tick.
- Gate low on the same tick as a segment-end transition: RELEASE takes priority; the tick's level update is still applied.
- RELEASE:
  - On tick, amplitude = max(amplitude-release_step, 0).
  - When the result is 0, go to IDLE.
  - Gate re-assertion during RELEASE is governed by the optional feature below.
- Latency: amplitude changes 1 clock after a tick cycle. state changes 1 clock after the condition is seen.

Optional Feature:
- Macro: ENVELOPE_RETRIGGER_EN
- Defined:
  - A rise seen in DECAY, SUSTAIN or RELEASE sends the block to ATTACK next cycle.
  - The attack continues from the current amplitude; there is no reset to 0.
- Undefined:
  - Rises outside IDLE are ignored.
  - A gate still high when RELEASE reaches IDLE starts a new ATTACK from 0 on the following cycle (IDLE rule).

Test Plan (all with TICK_DIV=4, DATA_BITS=8):
- Reset mid-ATTACK at amplitude 0x40 -> next cycle amplitude=0, state=0, busy=0; no further ticks change amplitude while gate=0.
- gate=1, attack_step=0x40, decay_step=0x20, sustain_level=0x80 -> amplitude 0x40,0x80,0xC0,0xFF (saturated, DECAY), 0xDF,0xBF,0x9F,0x80 (SUSTAIN); one update every 4 clocks.
- In SUSTAIN, change sustain_level to 0x30 -> amplitude=0x30 after the next tick; state stays 3.
- gate=0 in SUSTAIN at 0x80, release_step=0x50 -> state=4 next clock; amplitude 0x30, then 0x00, then state=0, busy=0.
- attack_step=0, decay_step=0 -> amplitude 0xFF on the first tick, sustain_level on the second tick.
- With ENVELOPE_RETRIGGER_EN defined: gate re-rises in RELEASE at 0x60 -> state=1, amplitude rises from 0x60. Without the macro: release continues to 0, then ATTACK restarts from 0.
